// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding, default widths and control vectors for pipeline_stall_ctrl
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN       = 1'b0,
      MEM_STALL = 1'b1
   } state_t;

   localparam int DEF_CNT_W  = 3;
   localparam int DEF_PERF_W = 16;

   typedef struct packed {
      logic pc_we;
      logic if_id_we;
      logic if_id_flush;
      logic id_ex_we;
      logic id_ex_bubble;
      logic ex_mem_we;
      logic mem_wb_bubble;
   } ctrl_t;

   // Field order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble
   localparam ctrl_t CTRL_RESET    = 7'b0010101;
   localparam ctrl_t CTRL_FREEZE   = 7'b0000001;
   localparam ctrl_t CTRL_FLUSH    = 7'b1111110;
   localparam ctrl_t CTRL_LOAD_USE = 7'b0001110;
   localparam ctrl_t CTRL_RUN      = 7'b1101010;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// rtl/pipeline_stall_ctrl_if.sv - stall request / stage control bundle; perf ports exist only with STALL_PERF_CNT_EN
interface pipeline_stall_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
`ifdef STALL_PERF_CNT_EN
   , parameter int PERF_W = DEF_PERF_W
`endif
);
   logic             HDU_stall_in;
   logic             branch_flush_EX_in;
   logic             mem_busy_req_in;
   logic [CNT_W-1:0] mem_busy_cycles_in;
   logic             pc_write_en_out;
   logic             IF_ID_write_en_out;
   logic             IF_ID_flush_out;
   logic             ID_EX_write_en_out;
   logic             ID_EX_bubble_out;
   logic             EX_MEM_write_en_out;
   logic             MEM_WB_bubble_out;
   logic             mem_stall_busy_out;
`ifdef STALL_PERF_CNT_EN
   logic [PERF_W-1:0] load_use_cnt_out;
   logic [PERF_W-1:0] mem_stall_cnt_out;
   logic [PERF_W-1:0] flush_cnt_out;
`endif

   modport master (
      output HDU_stall_in, branch_flush_EX_in, mem_busy_req_in, mem_busy_cycles_in,
      input  pc_write_en_out, IF_ID_write_en_out, IF_ID_flush_out, ID_EX_write_en_out,
             ID_EX_bubble_out, EX_MEM_write_en_out, MEM_WB_bubble_out, mem_stall_busy_out
`ifdef STALL_PERF_CNT_EN
      , input load_use_cnt_out, mem_stall_cnt_out, flush_cnt_out
`endif
   );

   modport slave (
      input  HDU_stall_in, branch_flush_EX_in, mem_busy_req_in, mem_busy_cycles_in,
      output pc_write_en_out, IF_ID_write_en_out, IF_ID_flush_out, ID_EX_write_en_out,
             ID_EX_bubble_out, EX_MEM_write_en_out, MEM_WB_bubble_out, mem_stall_busy_out
`ifdef STALL_PERF_CNT_EN
      , output load_use_cnt_out, mem_stall_cnt_out, flush_cnt_out
`endif
   );
endinterface

// File: rtl/mem_stall_counter.sv
// rtl/mem_stall_counter.sv - remaining MEM freeze cycles: load, decrement, last-cycle flag
module mem_stall_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             last_out
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_out = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - arbitrates load-use, branch flush and MEM freeze into stage controls
// Optional saturating perf counters under STALL_PERF_CNT_EN.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
`ifdef STALL_PERF_CNT_EN
   , parameter int PERF_W = DEF_PERF_W
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   pipeline_stall_ctrl_if.slave   bus
);
   state_t           state_q, state_d;
   ctrl_t            ctrl;
   logic             freeze_req;
   logic             cnt_load, cnt_dec, cnt_last;
   logic [CNT_W-1:0] cnt_load_val;
   logic             freeze_cyc, flush_cyc, load_use_cyc;

   assign freeze_req   = bus.mem_busy_req_in && (bus.mem_busy_cycles_in != '0);
   // The RUN cycle that accepts the request is the first freeze cycle.
   assign cnt_load_val = bus.mem_busy_cycles_in - CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      ctrl         = CTRL_RUN;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      freeze_cyc   = 1'b0;
      flush_cyc    = 1'b0;
      load_use_cyc = 1'b0;
      if (rst) begin
         ctrl    = CTRL_RESET;
         state_d = RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               if (freeze_req) begin
                  ctrl       = CTRL_FREEZE;
                  freeze_cyc = 1'b1;
                  if (bus.mem_busy_cycles_in > CNT_W'(1)) begin
                     cnt_load = 1'b1;
                     state_d  = MEM_STALL;
                  end
               end else if (bus.branch_flush_EX_in) begin
                  ctrl      = CTRL_FLUSH;
                  flush_cyc = 1'b1;
               end else if (bus.HDU_stall_in) begin
                  ctrl         = CTRL_LOAD_USE;
                  load_use_cyc = 1'b1;
               end
            end
            MEM_STALL: begin
               ctrl       = CTRL_FREEZE;
               freeze_cyc = 1'b1;
               cnt_dec    = 1'b1;
               if (cnt_last) begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   mem_stall_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .last_out (cnt_last)
   );

   assign bus.pc_write_en_out     = ctrl.pc_we;
   assign bus.IF_ID_write_en_out  = ctrl.if_id_we;
   assign bus.IF_ID_flush_out     = ctrl.if_id_flush;
   assign bus.ID_EX_write_en_out  = ctrl.id_ex_we;
   assign bus.ID_EX_bubble_out    = ctrl.id_ex_bubble;
   assign bus.EX_MEM_write_en_out = ctrl.ex_mem_we;
   assign bus.MEM_WB_bubble_out   = ctrl.mem_wb_bubble;
   assign bus.mem_stall_busy_out  = (state_q == MEM_STALL);

`ifdef STALL_PERF_CNT_EN
   logic [PERF_W-1:0] load_use_cnt_q, load_use_cnt_d;
   logic [PERF_W-1:0] mem_stall_cnt_q, mem_stall_cnt_d;
   logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      load_use_cnt_d  = load_use_cnt_q;
      mem_stall_cnt_d = mem_stall_cnt_q;
      flush_cnt_d     = flush_cnt_q;
      if (load_use_cyc && !(&load_use_cnt_q))  load_use_cnt_d  = load_use_cnt_q + PERF_W'(1);
      if (freeze_cyc && !(&mem_stall_cnt_q))   mem_stall_cnt_d = mem_stall_cnt_q + PERF_W'(1);
      if (flush_cyc && !(&flush_cnt_q))        flush_cnt_d     = flush_cnt_q + PERF_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_use_cnt_q  <= '0;
         mem_stall_cnt_q <= '0;
         flush_cnt_q     <= '0;
      end else begin
         load_use_cnt_q  <= load_use_cnt_d;
         mem_stall_cnt_q <= mem_stall_cnt_d;
         flush_cnt_q     <= flush_cnt_d;
      end
   end

   assign bus.load_use_cnt_out  = load_use_cnt_q;
   assign bus.mem_stall_cnt_out = mem_stall_cnt_q;
   assign bus.flush_cnt_out     = flush_cnt_q;
`endif
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer end of the hazard-detection stall request. Arbitrates three sources into the per-stage enable, flush and bubble controls of the 5-stage pipeline:
  - the load-use stall from the hazard unit;
  - the taken-branch flush from EX;
  - the multi-cycle memory busy request from MEM.
- Sits between the hazard unit, branch unit and memory stage on one side and the PC plus the IF/ID, ID/EX, EX/MEM and MEM/WB registers on the other.
- Adds a cycle counter for multi-cycle MEM freezes.

Parameters:
- CNT_W, 3, width of the memory busy cycle count (max freeze 2^CNT_W-1 cycles).
- PERF_W, 16, width of each optional performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- HDU_stall_in  input  1  load-use stall request (combinational, same cycle).
- branch_flush_EX_in  input  1  taken branch/jump resolved in EX.
- mem_busy_req_in  input  1  MEM instruction needs a multi-cycle access.
- mem_busy_cycles_in  input  CNT_W  total freeze cycles requested; valid with mem_busy_req_in.
- pc_write_en_out  output  1  PC update enable.
- IF_ID_write_en_out  output  1  IF/ID register load enable.
- IF_ID_flush_out  output  1  clear IF/ID to NOP.
- ID_EX_write_en_out  output  1  ID/EX register load enable.
- ID_EX_bubble_out  output  1  load NOP into ID/EX.
- EX_MEM_write_en_out  output  1  EX/MEM register load enable.
- MEM_WB_bubble_out  output  1  load NOP into MEM/WB.
- mem_stall_busy_out  output  1  high while in the MEM_STALL state (registered).
- Perf counters, present only with the optional feature: load_use_cnt_out, mem_stall_cnt_out, flush_cnt_out  output  PERF_W each.

Behaviour:
- States:
  - RUN: outputs are Mealy, combinational from the inputs.
  - MEM_STALL: outputs are Moore.
  - One down-counter, CNT_W bits.
- Reset (rst high at a clk edge): state RUN, counter 0, mem_stall_busy_out 0.
- While rst is high, outputs are forced regardless of state:
  - all write enables 0;
  - IF_ID_flush_out 1, ID_EX_bubble_out 1, MEM_WB_bubble_out 1.
  - Reset mid-MEM_STALL aborts the stall.
- RUN output priority (highest first):
  1. Memory freeze: mem_busy_req_in=1 and mem_busy_cycles_in>=1.
     - pc, IF_ID, ID_EX and EX_MEM write enables all 0.
     - MEM_WB_bubble_out 1; flush 0; ID_EX_bubble 0.
     - If cycles>=2: load counter with cycles-1 and go to MEM_STALL.
     - If cycles=1: stay in RUN.
  2. Branch flush: branch_flush_EX_in=1.
     - All write enables 1 (PC loads the target).
     - IF_ID_flush_out 1, ID_EX_bubble_out 1, MEM_WB_bubble_out 0.
  3. Load-use: HDU_stall_in=1.
     - pc_write_en_out 0, IF_ID_write_en_out 0.
     - ID_EX_write_en_out 1 with ID_EX_bubble_out 1.
     - EX_MEM_write_en_out 1, MEM_WB_bubble 0.
  4. Otherwise: all write enables 1, all flush/bubble 0.
- mem_busy_req_in with mem_busy_cycles_in=0 is treated as no request.
- MEM_STALL:
  - Same freeze outputs as priority 1 in RUN.
  - HDU_stall_in, branch_flush_EX_in and mem_busy_req_in are ignored. The EX/ID contents are frozen, so these requests are re-evaluated on the first RUN cycle.
  - Counter decrements each cycle.
  - When counter==1, next state is RUN and counter goes to 0.
  - Total freeze length therefore equals mem_busy_cycles_in exactly.
- Simultaneous branch + load-use: branch wins; the stalled instruction is wrong-path and gets flushed.
- mem_stall_busy_out = (state==MEM_STALL), registered.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- When defined, three PERF_W-bit counters are added:
  - load_use_cnt_out: cycles where priority 3 is taken.
  - mem_stall_cnt_out: every freeze cycle, RUN or MEM_STALL.
  - flush_cnt_out: cycles where priority 2 is taken.
- Counters are cleared by rst and saturate at all-ones (no wrap).
- When undefined, the counters and their ports are absent and the logic is otherwise identical.

Decomposition:
- Shared package/include pipe_ctrl_pkg:
  - state encoding: RUN=1'b0, MEM_STALL=1'b1;
  - default CNT_W and PERF_W;
  - the reset output vector.
- One natural sub-module, mem_stall_counter: load, decrement, last-cycle flag.
- Arbitration and outputs stay in the top module.

Test Plan:
- rst high for 2 cycles with all inputs 1 -> all enables 0, all flush/bubble 1; after release with inputs 0 -> all enables 1.
- HDU_stall_in=1 for 1 cycle -> that cycle pc_write_en=0, IF_ID_write_en=0, ID_EX_bubble=1; next cycle all enables 1.
- mem_busy_req_in=1, cycles=4 -> exactly 4 consecutive freeze cycles with MEM_WB_bubble=1 and mem_stall_busy_out high for the last 3; HDU_stall_in and branch_flush held high during the freeze are ignored, then honored on cycle 5.
- branch_flush_EX_in=1 and HDU_stall_in=1 together -> IF_ID_flush=1, ID_EX_bubble=1, pc_write_en=1.
- mem_busy_req_in=1, cycles=0 -> no freeze; cycles=1 -> single freeze cycle, state stays RUN; rst asserted on freeze cycle 2 of 7 -> RUN next cycle, counter 0.
- With STALL_PERF_CNT_EN and PERF_W=4: 20 freeze cycles -> mem_stall_cnt_out saturates at 15.
